cordic_polar2rect: RTL
======================

CORDIC_POLAR2RECT -- requirements
Module: cordic_polar2rect

Interface
REQ-001 Parameter ITER, default 8: number of CORDIC micro-rotations per sample, legal range 6..12.
REQ-002 aclk  in  1  sole clock; all state updates on rising edge.
REQ-003 areset  in  1  reset, synchronous, active-high.
REQ-004 s_axis_polar_tvalid  in  1  input sample valid.
REQ-005 s_axis_polar_tready  out  1  block can accept a sample.
REQ-006 s_axis_polar_tdata  in  16  [15:8] phase, signed 8-bit, 3 integer bits, 5 fraction bits, radians; [7:0] magnitude, signed 8-bit, 2 integer bits, 6 fraction bits.
REQ-007 m_axis_dout_tvalid  out  1  result valid.
REQ-008 m_axis_dout_tready  in  1  downstream accepts result.
REQ-009 m_axis_dout_tdata  out  16  [15:8] y = mag*sin(phase), [7:0] x = mag*cos(phase), each signed 8-bit with 2 integer bits and 6 fraction bits.

Function
REQ-010 FSM states: IDLE, ROTATE, DONE; only one sample in flight.
REQ-011 IDLE: s_axis_polar_tready=1; on tvalid&&tready go to ROTATE and load the datapath; otherwise stay.
REQ-012 ROTATE: tready=0; one micro-rotation per cycle, i=0..ITER-1; after iteration ITER-1 the output register loads and the FSM goes to DONE.
REQ-013 DONE: m_axis_dout_tvalid=1; tdata stable while tready=0; on m_axis_dout_tready=1 go to IDLE at that edge.
REQ-014 Latency: handshake at edge k -> m_axis_dout_tvalid high after edge k+ITER; minimum throughput one sample per ITER+2 cycles.
REQ-015 Phase clamp: codes above +100 (8'h64) become +100, below -100 (8'h9C) become -100.
REQ-016 Quadrant pre-rotation: phase > +pi/2 (code > 50) gives start vector (0, m) with residual phase-pi/2; phase < -pi/2 (code < -50) gives (0, -m) with residual phase+pi/2; otherwise start (m, 0).
REQ-017 Gain pre-scale: m = mag*(2^-1 + 2^-3 - 2^-6 - 2^-9), shift-add only, no multiplier.
REQ-018 Internal x/y signed 16-bit, 2 integer bits, 14 fraction bits; internal angle signed 16-bit, 3 integer bits, 13 fraction bits.
REQ-019 atan(2^-i) table constants are rounded to the internal angle format.
REQ-020 Iteration i: d = +1 if residual angle >= 0, else -1; x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan(2^-i); shifts arithmetic.
REQ-021 Output conversion: round half-up at bit 6 of the fraction, then saturate to the range 8'h80..8'h7F.
REQ-022 Accuracy: x and y within +/-2 LSB of the ideal rounded values for every legal input.
REQ-023 Input handshake with tvalid high in ROTATE or DONE: sample is not consumed and is accepted on the first IDLE cycle.
REQ-024 A single result is never dropped or duplicated.

Reset
REQ-025 areset high at a rising edge: FSM -> IDLE; s_axis_polar_tready=0 during reset, then 1 on the first cycle after reset deasserts.
REQ-026 Reset values: m_axis_dout_tvalid=0, m_axis_dout_tdata=16'h0000, iteration counter=0, all datapath registers cleared.
REQ-027 Reset in ROTATE or DONE abandons the sample with no output produced; areset has priority over all handshakes at the same edge.

Verification
REQ-028 Zero phase: mag=8'h2D, phase=8'h00 -> x=8'h2D +/-2, y=8'h00 +/-2, tvalid high ITER cycles after the handshake.
REQ-029 Phase +pi/4: mag=8'h20, phase=8'h19 -> x=8'h17 +/-2, y=8'h16 +/-2.
REQ-030 Phase 3pi/4: mag=8'h10, phase=8'h4B -> x=8'hF5 +/-2, y=8'h0B +/-2; a following negative-phase sample (8'hE7, mag 8'h20) -> x=8'h17 +/-2, y=8'hEA +/-2.
REQ-031 Clamp: mag=8'h20, phase=8'h7F -> x=8'hE0 +/-2, y=8'h00 +/-2.
REQ-032 Backpressure: m_axis_dout_tready low 5 cycles -> tvalid and tdata stay constant, s_axis_polar_tready stays 0, and exactly one result transfers when tready rises.
REQ-033 Mid-operation reset: areset pulsed at iteration 3 -> no output; a new sample after reset yields the correct result with the nominal latency.

Source files
------------

// File: rtl/cordic_polar2rect.sv
// Polar-to-rectangular converter built on an iterative CORDIC rotator.
// One sample is in flight at a time: it is accepted in IDLE, rotated one
// micro-step per cycle in ROTATE, then held in DONE until downstream takes it.
//
// Handshake: on both streams a transfer happens on a rising edge where
// tvalid and tready are both high. The source holds tvalid/tdata until that
// edge; tready never waits on tvalid on either side, and areset overrides
// any transfer at the same edge.
module cordic_polar2rect #(
    parameter int ITER = 8  // micro-rotations per sample, usable range 6..12
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        s_axis_polar_tvalid,
    output logic        s_axis_polar_tready,
    input  logic [15:0] s_axis_polar_tdata,
    output logic        m_axis_dout_tvalid,
    input  logic        m_axis_dout_tready,
    output logic [15:0] m_axis_dout_tdata,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROTATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Index of the last micro-rotation; the counter is 4 bits wide for ITER <= 12.
    localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

    // pi/2 in the internal angle format (3 integer bits, 13 fraction bits).
    localparam logic signed [15:0] HALF_PI = 16'sd12868;

    // Phase limits in input codes (3.5 format): +/-100 is about +/-3.125 rad.
    localparam logic signed [7:0] PHASE_MAX = 8'sd100;
    localparam logic signed [7:0] PHASE_MIN = -8'sd100;

    // Codes beyond +/-50 lie outside the CORDIC convergence band and are
    // folded back by a quarter turn before the micro-rotations start.
    localparam logic signed [7:0] QUAD_HI = 8'sd50;
    localparam logic signed [7:0] QUAD_LO = -8'sd50;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_iter;
    logic signed [15:0] r_x;
    logic signed [15:0] r_y;
    logic signed [15:0] r_z;
    logic [15:0]        r_dout;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic               w_accept;
    logic               w_last;
    logic signed [7:0]  w_phase_in;
    logic signed [7:0]  w_mag_in;
    logic signed [7:0]  w_phase_clamp;
    logic signed [15:0] w_z_in;
    logic signed [15:0] w_mag_ext;
    logic signed [15:0] w_m;
    logic signed [15:0] w_x0;
    logic signed [15:0] w_y0;
    logic signed [15:0] w_z0;
    logic signed [15:0] w_x_sh;
    logic signed [15:0] w_y_sh;
    logic signed [15:0] w_atan;
    logic signed [15:0] w_x_next;
    logic signed [15:0] w_y_next;
    logic signed [15:0] w_z_next;
    logic [7:0]         w_x_out;
    logic [7:0]         w_y_out;

    // ------------------------------------------------------------------
    // atan(2^-i) rounded to the internal angle format (13 fraction bits).
    // ------------------------------------------------------------------
    function automatic logic signed [15:0] atan_lut(input logic [3:0] idx);
        logic signed [15:0] v;
        case (idx)
            4'd0:    v = 16'sd6434;
            4'd1:    v = 16'sd3798;
            4'd2:    v = 16'sd2007;
            4'd3:    v = 16'sd1019;
            4'd4:    v = 16'sd511;
            4'd5:    v = 16'sd256;
            4'd6:    v = 16'sd128;
            4'd7:    v = 16'sd64;
            4'd8:    v = 16'sd32;
            4'd9:    v = 16'sd16;
            4'd10:   v = 16'sd8;
            4'd11:   v = 16'sd4;
            default: v = 16'sd0;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Drop 8 fraction bits with round-half-up, saturating at the top.
    // Adding a positive bias can only overflow upwards, so the negative
    // limit 8'h80 is reached naturally and needs no clamp.
    // ------------------------------------------------------------------
    function automatic logic [7:0] round_sat(input logic signed [15:0] v);
        logic [16:0] s;
        logic [7:0]  r;
        s = {v[15], v} + 17'd128;
        if (s[16:15] == 2'b01) begin
            r = 8'h7F;
        end else begin
            r = s[15:8];
        end
        return r;
    endfunction

    assign w_phase_in = s_axis_polar_tdata[15:8];
    assign w_mag_in   = s_axis_polar_tdata[7:0];
    assign w_accept   = s_axis_polar_tvalid && s_axis_polar_tready;
    assign w_last     = (r_state == S_ROTATE) && (r_iter == LAST_ITER);

    assign m_axis_dout_tdata = r_dout;
    assign o_dbg_state       = r_state;

    // State register; reset wins over every handshake at the same edge.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_next        = r_state;
        s_axis_polar_tready = 1'b0;
        m_axis_dout_tvalid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                s_axis_polar_tready = !areset;
                if (s_axis_polar_tvalid) begin
                    w_state_next = S_ROTATE;
                end
            end
            S_ROTATE: begin
                if (r_iter == LAST_ITER) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                m_axis_dout_tvalid = 1'b1;
                if (m_axis_dout_tready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Limit the incoming phase to +/-100 codes and widen it to the angle format.
    always_comb begin
        w_phase_clamp = w_phase_in;
        if (w_phase_in > PHASE_MAX) begin
            w_phase_clamp = PHASE_MAX;
        end else if (w_phase_in < PHASE_MIN) begin
            w_phase_clamp = PHASE_MIN;
        end
        w_z_in = {w_phase_clamp, 8'h00};
    end

    // Pre-scale the magnitude by ~1/K (0.607422) with shifts and adds so the
    // rotator gain is cancelled up front.
    always_comb begin
        w_mag_ext = {w_mag_in, 8'h00};
        w_m = (w_mag_ext >>> 1) + (w_mag_ext >>> 3)
            - (w_mag_ext >>> 6) - (w_mag_ext >>> 9);
    end

    // Quarter-turn pre-rotation keeps the residual angle inside the
    // convergence band of the micro-rotations.
    always_comb begin
        w_x0 = w_m;
        w_y0 = 16'sd0;
        w_z0 = w_z_in;
        if (w_phase_clamp > QUAD_HI) begin
            w_x0 = 16'sd0;
            w_y0 = w_m;
            w_z0 = w_z_in - HALF_PI;
        end else if (w_phase_clamp < QUAD_LO) begin
            w_x0 = 16'sd0;
            w_y0 = -w_m;
            w_z0 = w_z_in + HALF_PI;
        end
    end

    // One micro-rotation: turn towards zero residual angle.
    always_comb begin
        w_x_sh = r_x >>> r_iter;
        w_y_sh = r_y >>> r_iter;
        w_atan = atan_lut(r_iter);
        if (!r_z[15]) begin
            w_x_next = r_x - w_y_sh;
            w_y_next = r_y + w_x_sh;
            w_z_next = r_z - w_atan;
        end else begin
            w_x_next = r_x + w_y_sh;
            w_y_next = r_y - w_x_sh;
            w_z_next = r_z + w_atan;
        end
    end

    // Output format conversion of the final micro-rotation result.
    always_comb begin
        w_x_out = round_sat(w_x_next);
        w_y_out = round_sat(w_y_next);
    end

    // Datapath: load on accept, rotate while in ROTATE, capture the result
    // on the last iteration so it is visible the same edge DONE is entered.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_iter <= 4'd0;
            r_x    <= 16'sd0;
            r_y    <= 16'sd0;
            r_z    <= 16'sd0;
            r_dout <= 16'h0000;
        end else if (w_accept) begin
            r_iter <= 4'd0;
            r_x    <= w_x0;
            r_y    <= w_y0;
            r_z    <= w_z0;
        end else if (r_state == S_ROTATE) begin
            r_x <= w_x_next;
            r_y <= w_y_next;
            r_z <= w_z_next;
            if (w_last) begin
                r_iter <= 4'd0;
                r_dout <= {w_y_out, w_x_out};
            end else begin
                r_iter <= r_iter + 4'd1;
            end
        end
    end

endmodule
